// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared state encoding and counter sizing for the sequential multiplier
package mul_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mul_seq_rca.sv
// rtl/mul_seq_rca.sv - w-bit ripple-carry adder with carry in and carry out
module mul_seq_rca #(
  parameter int w = 8
) (
  input  logic [w-1:0] a,
  input  logic [w-1:0] b,
  input  logic         cin,
  output logic [w-1:0] sum,
  output logic         cout
);

  logic [w:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < w; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[w];

endmodule

// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - radix-2 shift-add multiplier, one adder reused over bw cycles
// MUL_SIGNED_EN adds the sgn port and a FIX state that negates the magnitude product.
module mul_seq
  import mul_pkg::*;
#(
  parameter int bw = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [bw-1:0]   x,
  input  logic [bw-1:0]   y,
`ifdef MUL_SIGNED_EN
  input  logic            sgn,
`endif
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*bw-1:0] p
);

  localparam int pw = 2 * bw;
  localparam int cw = cnt_w(bw);

  state_e          state_q, state_d;
  logic [bw-1:0]   mcand_q, mcand_d;
  logic [pw-1:0]   acc_q, acc_d;
  logic [cw-1:0]   count_q, count_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic [pw-1:0]   p_q, p_d;
`ifdef MUL_SIGNED_EN
  logic            neg_q, neg_d;
`endif

  logic [bw-1:0]   addend;
  logic [bw-1:0]   sum;
  logic            cout;
  logic [pw-1:0]   acc_step;

  // Only the upper half is added into; the low half shifts the multiplier out.
  assign addend   = acc_q[0] ? mcand_q : '0;
  assign acc_step = {cout, sum, acc_q[bw-1:1]};

  mul_seq_rca #(.w(bw)) u_rca (
    .a    (acc_q[pw-1:bw]),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    acc_d       = acc_q;
    count_d     = count_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    p_d         = p_q;
`ifdef MUL_SIGNED_EN
    neg_d       = neg_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mcand_d    = x;
          acc_d      = {{bw{1'b0}}, y};
          count_d    = '0;
`ifdef MUL_SIGNED_EN
          neg_d      = 1'b0;
          if (sgn) begin
            // -2^(bw-1) negates to itself, which read unsigned is the exact magnitude
            mcand_d = x[bw-1] ? -x : x;
            acc_d   = {{bw{1'b0}}, (y[bw-1] ? -y : y)};
            neg_d   = x[bw-1] ^ y[bw-1];
          end
`endif
          in_ready_d = 1'b0;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        acc_d   = acc_step;
        count_d = count_q + cw'(1);
        if (count_q == cw'(bw - 1)) begin
`ifdef MUL_SIGNED_EN
          state_d     = S_FIX;
`else
          p_d         = acc_step;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
`endif
        end
      end
`ifdef MUL_SIGNED_EN
      S_FIX: begin
        acc_d       = neg_q ? -acc_q : acc_q;
        p_d         = neg_q ? -acc_q : acc_q;
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
`endif
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mcand_q     <= '0;
      acc_q       <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      p_q         <= '0;
`ifdef MUL_SIGNED_EN
      neg_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      p_q         <= p_d;
`ifdef MUL_SIGNED_EN
      neg_q       <= neg_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign p         = p_q;

endmodule

// File: tb/tb_mul_seq.sv
// tb/tb_mul_seq.sv - directed and randomized self-checking bench for mul_seq (bw=8)
module tb_mul_seq;

  localparam int BW = 8;
  localparam int PW = 16;
`ifdef MUL_SIGNED_EN
  localparam int LAT = 10;
`else
  localparam int LAT = 9;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] x, y;
  logic          sgn;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] p;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_seq #(.bw(BW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
`ifdef MUL_SIGNED_EN
    .sgn       (sgn),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // all tasks start and end at a falling edge
  task automatic accept(input logic [BW-1:0] xa, input logic [BW-1:0] ya, input logic sa);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); @(negedge clk); n++;
    end
    if (n >= 50) check("accept_timeout", 32'd0, 32'd1);
    x = xa; y = ya; sgn = sa; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input logic [PW-1:0] exp, input bit junk);
    int lat = 1;
    while (!out_valid && lat < 40) begin
      if (junk) begin
        in_valid = 1'b1; x = 8'h5A; y = 8'hA5;
      end
      @(posedge clk); @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    check({tag, "_lat"}, lat, LAT);
    check({tag, "_p"}, p, exp);
  endtask

  task automatic op(input string tag, input logic [BW-1:0] xa, input logic [BW-1:0] ya,
                    input logic sa, input logic [PW-1:0] exp);
    accept(xa, ya, sa);
    wait_result(tag, exp, 1'b0);
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    bit saw;
    rst = 1'b1; in_valid = 1'b0; x = '0; y = '0; sgn = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_p", p, 16'h0000);
    rst = 1'b0;
    @(negedge clk);

    op("ff_ff", 8'd255, 8'd255, 1'b0, 16'hFE01);
    op("zero_x", 8'd0, 8'd173, 1'b0, 16'h0000);
    op("d13_11", 8'd13, 8'd11, 1'b0, 16'h008F);
    op("x80_02", 8'h80, 8'h02, 1'b0, 16'h0100);

    // reset clears a non-zero product
    rst = 1'b1; #1;
    check("rst2_p", p, 16'h0000);
    check("rst2_in_ready", in_ready, 1);
    @(negedge clk); rst = 1'b0; @(negedge clk);

    // backpressure with in_valid pushed during the run
    out_ready = 1'b0;
    accept(8'd13, 8'd11, 1'b0);
    wait_result("bp", 16'h008F, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      check("bp_valid_held", out_valid, 1);
      check("bp_p_held", p, 16'h008F);
      check("bp_in_ready_low", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    check("bp_released_valid", out_valid, 0);
    check("bp_released_ready", in_ready, 1);

    // abort mid-RUN at count=4
    accept(8'd200, 8'd3, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; #1;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    @(negedge clk); rst = 1'b0;
    saw = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) saw = 1'b1;
    end
    check("abort_no_valid", saw, 0);
    op("after_abort", 8'd7, 8'd9, 1'b0, 16'h003F);

`ifdef MUL_SIGNED_EN
    op("s_m3_5", 8'hFD, 8'h05, 1'b1, 16'hFFF1);
    op("s_m128_m128", 8'h80, 8'h80, 1'b1, 16'h4000);
    op("s_m128_1", 8'h80, 8'h01, 1'b1, 16'hFF80);
    op("s_u80_02", 8'h80, 8'h02, 1'b0, 16'h0100);
`endif

    // random ops, random out_ready, checked against a multiply model
    for (int i = 0; i < 300; i++) begin
      logic [BW-1:0] ra, rb;
      logic          rs;
      logic [PW-1:0] exp;
      int            n;
      int            ia, ib;
      bit            done;
      ra = BW'($urandom);
      rb = BW'($urandom);
`ifdef MUL_SIGNED_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      ia = rs ? int'($signed(ra)) : int'(ra);
      ib = rs ? int'($signed(rb)) : int'(rb);
      exp = PW'(ia * ib);
      accept(ra, rb, rs);
      n = 0; done = 1'b0;
      while (!done && n < 100) begin
        out_ready = 1'($urandom);
        if (out_valid && out_ready) begin
          check("rand_p", p, exp);
          done = 1'b1;
        end
        @(posedge clk); @(negedge clk);
        n++;
      end
      if (!done) check("rand_timeout", 32'd0, 32'd1);
    end
    out_ready = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
